// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - 2-thread interleaved fetch scheduler with slot tagging, squash and halt drain.
// Optional THREAD_SCHED_BURST_EN: a lone active thread is fetched every cycle instead of every other.
module thread_scheduler #(
  parameter int PIPE_DEPTH = 4,
  parameter int HALT_STAGE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  halt_req,
  input  logic                  branch_taken,
  input  logic                  branch_tid,
  output logic                  fetch_valid,
  output logic                  fetch_thread_id,
  output logic [PIPE_DEPTH-1:0] squash_mask,
  output logic [1:0]            thread_active,
  output logic                  done
);

`ifdef THREAD_SCHED_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic                    fetch_tid_q, fetch_tid_d;
  logic [1:0]              active_q, active_d;
  logic [PIPE_DEPTH-1:1]   slot_v_q;
  logic [PIPE_DEPTH-1:1]   slot_t_q;

  // Slot 0 is the fetch register itself; older slots are the shifted tags.
  logic [PIPE_DEPTH-1:0]   slot_v;
  logic [PIPE_DEPTH-1:0]   slot_t;
  logic [PIPE_DEPTH-1:0]   br_mask;
  logic [PIPE_DEPTH-1:0]   halt_mask;
  logic                    br_any;
  logic                    halt_ok;
  logic                    halt_tid;
  logic                    cand;
  logic                    can_issue;

  assign slot_v = {slot_v_q, fetch_valid_q};
  assign slot_t = {slot_t_q, fetch_tid_q};

  always_comb begin
    br_mask = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      br_mask[i] = branch_taken & slot_v[i] & (slot_t[i] == branch_tid);
    end
    // The resolving branch itself sits in the last slot and commits.
    br_mask[PIPE_DEPTH-1] = 1'b0;
    br_any   = |br_mask;

    halt_tid = slot_t[HALT_STAGE];
    halt_ok  = halt_req & slot_v[HALT_STAGE] & ~br_mask[HALT_STAGE];
    halt_mask = '0;
    for (int i = 0; i < HALT_STAGE; i++) begin
      halt_mask[i] = halt_ok & slot_v[i] & (slot_t[i] == halt_tid);
    end
    squash_mask = br_mask | halt_mask;

    active_d = active_q;
    if (halt_ok) begin
      active_d[halt_tid] = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    fetch_valid_d = 1'b0;
    fetch_tid_d   = fetch_tid_q;
    cand          = rr_q;
    can_issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (active_d == 2'b00) begin
          state_d = S_DRAIN;
        end else begin
          if (&active_d) begin
            cand      = rr_q;
            can_issue = 1'b1;
          end else begin
            // Lone thread: keep a bubble after each fetch unless bursting.
            cand      = active_d[1];
            can_issue = BURST | ~fetch_valid_q;
          end
          if (can_issue && !(br_any && (cand == branch_tid))) begin
            fetch_valid_d = 1'b1;
            fetch_tid_d   = cand;
            rr_d          = ~cand;
          end
        end
      end
      S_DRAIN: begin
        if (slot_v == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_q          <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_tid_q   <= 1'b0;
      active_q      <= 2'b11;
      slot_v_q      <= '0;
      slot_t_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_tid_q   <= fetch_tid_d;
      active_q      <= active_d;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        slot_v_q[i] <= slot_v[i-1] & ~squash_mask[i-1];
        slot_t_q[i] <= slot_t[i-1];
      end
    end
  end

  assign fetch_valid     = fetch_valid_q;
  assign fetch_thread_id = fetch_tid_q;
  assign thread_active   = active_q;
  assign done            = (state_q == S_DONE);

endmodule
